// File: rtl/pipe_frame_tx_pkg.sv
// Shared frame definitions for the system-side transmitter and any host-side checker:
// state encodings, default sync byte and the word offsets inside a frame.
package pipe_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LEN  = 3'd2,
    PAY  = 3'd3,
    SUM  = 3'd4
  } frame_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Word positions within a frame; the checksum follows the payload.
  localparam int unsigned WORD_OFS_HDR = 0;
  localparam int unsigned WORD_OFS_LEN = 1;
  localparam int unsigned WORD_OFS_PAY = 2;

  function automatic int unsigned word_ofs_sum(input int unsigned len);
    return WORD_OFS_PAY + len;
  endfunction

  function automatic logic [15:0] header_word(input logic [7:0] sync, input logic [7:0] seq);
    return {sync, seq};
  endfunction

endpackage

// File: rtl/pipe_frame_tx.sv
// Frame transmitter: emits header, length, payload pulled from a request/valid source,
// and a 16-bit additive checksum into the host pipe-out FIFO write port.
module pipe_frame_tx
  import pipe_frame_tx_pkg::*;
#(
  parameter int         LEN_WIDTH = 16,
  parameter logic [7:0] SYNC      = SYNC_DEFAULT
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  output logic                 busy,
  output logic                 done,
  output logic                 src_ready,
  input  logic                 src_valid,
  input  logic [15:0]          src_data,
  input  logic                 sys_tx_ready,
  output logic                 sys_tx_valid,
  output logic [15:0]          sys_tx
);

  frame_state_t         state_reg, state_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic [LEN_WIDTH-1:0] req_cnt_reg, req_cnt_next;
  logic [LEN_WIDTH-1:0] rcv_cnt_reg, rcv_cnt_next;
  logic [LEN_WIDTH-1:0] rcv_cnt_inc;
  logic [15:0]          checksum_reg, checksum_next;
  logic [7:0]           seq_reg, seq_next;
  logic                 sum_sent_reg, sum_sent_next;
  logic                 busy_next, done_next, src_ready_next, tx_valid_next;
  logic [15:0]          tx_next;

  assign rcv_cnt_inc = rcv_cnt_reg + LEN_WIDTH'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      req_cnt_reg  <= '0;
      rcv_cnt_reg  <= '0;
      checksum_reg <= '0;
      seq_reg      <= '0;
      sum_sent_reg <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      src_ready    <= 1'b0;
      sys_tx_valid <= 1'b0;
      sys_tx       <= '0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      req_cnt_reg  <= req_cnt_next;
      rcv_cnt_reg  <= rcv_cnt_next;
      checksum_reg <= checksum_next;
      seq_reg      <= seq_next;
      sum_sent_reg <= sum_sent_next;
      busy         <= busy_next;
      done         <= done_next;
      src_ready    <= src_ready_next;
      sys_tx_valid <= tx_valid_next;
      sys_tx       <= tx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    req_cnt_next   = req_cnt_reg;
    rcv_cnt_next   = rcv_cnt_reg;
    checksum_next  = checksum_reg;
    seq_next       = seq_reg;
    sum_sent_next  = sum_sent_reg;
    busy_next      = busy;
    done_next      = 1'b0;
    src_ready_next = 1'b0;
    tx_valid_next  = 1'b0;
    tx_next        = sys_tx;

    case (state_reg)
      IDLE: begin
        if (start) begin
          len_next      = cfg_len;
          req_cnt_next  = '0;
          rcv_cnt_next  = '0;
          checksum_next = '0;
          sum_sent_next = 1'b0;
          busy_next     = 1'b1;
          state_next    = HDR;
        end
      end
      HDR: begin
        if (sys_tx_ready) begin
          tx_valid_next = 1'b1;
          tx_next       = header_word(SYNC, seq_reg);
          state_next    = LEN;
        end
      end
      LEN: begin
        if (sys_tx_ready) begin
          tx_valid_next = 1'b1;
          tx_next       = 16'(len_reg);
          state_next    = (len_reg == '0) ? SUM : PAY;
        end
      end
      PAY: begin
        // Requests stop as soon as the FIFO signals almost-full; in-flight data still lands.
        src_ready_next = sys_tx_ready && (req_cnt_reg != len_reg);
        if (src_ready_next) begin
          req_cnt_next = req_cnt_reg + LEN_WIDTH'(1);
        end
        // Only data answering an outstanding request is forwarded.
        if (src_valid && (rcv_cnt_reg != req_cnt_reg)) begin
          tx_valid_next = 1'b1;
          tx_next       = src_data;
          checksum_next = checksum_reg + src_data;
          rcv_cnt_next  = rcv_cnt_inc;
          if (rcv_cnt_inc == len_reg) begin
            state_next = SUM;
          end
        end
      end
      SUM: begin
        // Linger one cycle after the checksum push so busy covers it and done follows it.
        if (sum_sent_reg) begin
          sum_sent_next = 1'b0;
          done_next     = 1'b1;
          busy_next     = 1'b0;
          seq_next      = seq_reg + 8'd1;
          state_next    = IDLE;
        end else if (sys_tx_ready) begin
          tx_valid_next = 1'b1;
          tx_next       = checksum_reg;
          sum_sent_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_frame_tx.sv
// Self-checking bench for pipe_frame_tx: table of frames plus backpressure,
// back-to-back sequence wrap and mid-frame reset sequences, all checked via a word scoreboard.
module tb_pipe_frame_tx;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        start;
  logic [15:0] cfg_len;
  logic        busy;
  logic        done;
  logic        src_ready;
  logic        src_valid;
  logic [15:0] src_data;
  logic        sys_tx_ready;
  logic        sys_tx_valid;
  logic [15:0] sys_tx;

  always #5 sys_clk = ~sys_clk;

  pipe_frame_tx dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .cfg_len      (cfg_len),
    .busy         (busy),
    .done         (done),
    .src_ready    (src_ready),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .sys_tx_ready (sys_tx_ready),
    .sys_tx_valid (sys_tx_valid),
    .sys_tx       (sys_tx)
  );

  typedef struct {
    int          len;
    logic [15:0] base;
    logic [15:0] step;
    int          hold;
    logic [15:0] exp_sum;
  } vec_t;

  vec_t        vecs [6];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q [$];
  logic [15:0] src_q [$];
  logic [15:0] pay_buf [64];
  logic [7:0]  model_seq = 8'h00;
  int          cyc = 0;
  int          start_cyc, first_push_cyc, push_cnt, done_cnt, req_seen, bp_viol;
  logic [15:0] first_word, last_tx;
  bit          spur = 1'b0;
  bit          bp_active = 1'b0;
  int          bp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: source answers the previous cycle's request, then outputs are monitored.
  task automatic tick();
    logic pend, rdy_prev;
    pend     = src_ready;
    rdy_prev = sys_tx_ready;
    @(posedge sys_clk);
    #1;
    cyc++;
    src_valid = pend | spur;
    if (pend) src_data = (src_q.size() > 0) ? src_q.pop_front() : 16'hDEAD;
    else      src_data = 16'h5555;
    if (src_ready) begin
      req_seen++;
      if (!rdy_prev) bp_viol++;
    end
    if (done) done_cnt++;
    if (sys_tx_valid) begin
      push_cnt++;
      if (first_push_cyc < 0) begin
        first_push_cyc = cyc;
        first_word     = sys_tx;
      end
      last_tx = sys_tx;
      check("busy_during_push", busy, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_push", sys_tx, 32'hFFFF_FFFF);
      end else begin
        check("frame_word", sys_tx, exp_q.pop_front());
      end
    end
    if (bp_active) begin
      if (req_seen >= 3 && bp_cnt < 4) begin
        sys_tx_ready = 1'b0;
        bp_cnt++;
      end else begin
        sys_tx_ready = 1'b1;
      end
    end
  endtask

  task automatic frame_setup(input int len);
    logic [15:0] sum;
    sum = 16'h0000;
    exp_q.push_back({8'hA5, model_seq});
    exp_q.push_back(16'(len));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pay_buf[i]);
      src_q.push_back(pay_buf[i]);
      sum = sum + pay_buf[i];
    end
    exp_q.push_back(sum);
    done_cnt       = 0;
    req_seen       = 0;
    bp_viol        = 0;
    push_cnt       = 0;
    first_push_cyc = -1;
    cfg_len        = 16'(len);
    start          = 1'b1;
    start_cyc      = cyc;
  endtask

  task automatic run_frame(input int len, input int hold, input bit poke, input bit linger);
    int to;
    frame_setup(len);
    tick();
    start   = 1'b0;
    cfg_len = 16'($urandom);
    if (hold > 0) begin
      sys_tx_ready = 1'b0;
      repeat (hold) tick();
      sys_tx_ready = 1'b1;
    end
    if (poke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    to = 0;
    while (done_cnt == 0 && to < 2000) begin
      tick();
      to++;
    end
    if (done_cnt == 0) begin
      check("done_timeout", 0, 1);
    end else begin
      check("busy_at_done", busy, 0);
      model_seq = model_seq + 8'd1;
    end
    if (linger) begin
      tick();
      tick();
      check("done_pulses", done_cnt, 1);
    end
    check("header_latency", first_push_cyc - start_cyc, 2 + hold);
    check("push_count", push_cnt, len + 3);
    check("src_requests", req_seen, len);
    check("scoreboard_empty", exp_q.size(), 0);
    check("source_drained", src_q.size(), 0);
    check("req_after_ready_low", bp_viol, 0);
    $display("frame seq=%02h len=%0d hold=%0d hdr=%04h sum=%04h pushes=%0d", model_seq - 8'd1,
             len, hold, first_word, last_tx, push_cnt);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    start     = 1'b0;
    spur      = 1'b0;
    src_valid = 1'b0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
    model_seq = 8'h00;
    exp_q.delete();
    src_q.delete();
  endtask

  initial begin
    logic [15:0] w;
    int          to;
    vecs[0] = '{3, 16'h0001, 16'h0001, 0, 16'h0006};
    vecs[1] = '{0, 16'h0000, 16'h0000, 0, 16'h0000};
    vecs[2] = '{2, 16'hFFFF, 16'h0003, 0, 16'h0001};
    vecs[3] = '{4, 16'h1000, 16'h1000, 2, 16'hA000};
    vecs[4] = '{5, 16'h8000, 16'h0000, 1, 16'h8000};
    vecs[5] = '{1, 16'h1234, 16'h0000, 3, 16'h1234};

    sys_rst_n    = 1'b0;
    start        = 1'b0;
    cfg_len      = 16'h0000;
    src_valid    = 1'b0;
    src_data     = 16'h0000;
    sys_tx_ready = 1'b1;
    repeat (3) tick();
    check("rst_sys_tx_valid", sys_tx_valid, 0);
    check("rst_sys_tx", sys_tx, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    sys_rst_n = 1'b1;
    tick();

    // Unrequested source data while idle must be dropped.
    push_cnt = 0;
    spur = 1'b1;
    tick();
    tick();
    spur = 1'b0;
    tick();
    tick();
    check("idle_spurious_push", push_cnt, 0);

    for (int v = 0; v < 6; v++) begin
      w = vecs[v].base;
      for (int i = 0; i < vecs[v].len; i++) begin
        pay_buf[i] = w;
        w = w + vecs[v].step;
      end
      run_frame(vecs[v].len, vecs[v].hold, 1'b0, 1'b1);
      check("checksum_word", last_tx, vecs[v].exp_sum);
    end

    // Backpressure: ready low for 4 cycles after the 3rd payload request.
    for (int i = 0; i < 8; i++) pay_buf[i] = 16'($urandom);
    bp_cnt    = 0;
    bp_active = 1'b1;
    run_frame(8, 0, 1'b0, 1'b1);
    bp_active    = 1'b0;
    sys_tx_ready = 1'b1;
    check("bp_stall_cycles", bp_cnt, 4);

    // Reset in the middle of the payload.
    for (int i = 0; i < 8; i++) pay_buf[i] = 16'($urandom);
    frame_setup(8);
    tick();
    start = 1'b0;
    to = 0;
    while (push_cnt < 4 && to < 100) begin
      tick();
      to++;
    end
    check("reached_payload", push_cnt >= 4, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_sys_tx_valid", sys_tx_valid, 0);
    check("arst_sys_tx", sys_tx, 0);
    check("arst_src_ready", src_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    exp_q.delete();
    src_q.delete();
    src_valid = 1'b0;
    done_cnt  = 0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    model_seq = 8'h00;
    tick();
    check("no_done_after_reset", done_cnt, 0);
    pay_buf[0] = 16'h0102;
    pay_buf[1] = 16'h0304;
    run_frame(2, 0, 1'b0, 1'b1);
    check("post_reset_header", first_word, 16'hA500);

    // 257 back-to-back frames: seq wraps, a start while busy is ignored.
    do_reset();
    for (int f = 0; f < 257; f++) begin
      pay_buf[0] = 16'(f);
      run_frame(1, 0, (f == 100), 1'b0);
      check("seq_header", first_word, {8'hA5, 8'(f)});
    end
    push_cnt = 0;
    repeat (10) tick();
    check("no_extra_frame", push_cnt, 0);
    check("idle_after_burst", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
